rat_io_hub: RTL
===============

Name: rat_io_hub

Overview:
- Parametrised port-I/O hub between the RAT MCU (IN_PORT/OUT_PORT/PORT_ID/IO_STRB) and board peripherals.
- Decodes PORT_ID into N_IN byte-wide read ports and N_OUT 16-bit write registers. Each write register is reached through two byte addresses, with optional atomic 16-bit commit.
- Contains an N_IRQ-source interrupt controller (edge capture, mask, write-1-to-clear acknowledge) that drives the MCU interrupt. Replaces the hand-coded port muxes and single-interrupt wiring at the top level.

Parameters:
- N_IN, 2, number of 8-bit input ports; IDs IN_BASE..IN_BASE+N_IN-1.
- N_OUT, 3, number of 16-bit output registers; register i uses IDs OUT_BASE+2i (low byte) and OUT_BASE+2i+1 (high byte).
- N_IRQ, 4, interrupt sources (1..8).
- IN_BASE, 8'h20, first input port ID.
- OUT_BASE, 8'h40, first output port ID.
- IRQ_STAT_ID, 8'hF0, read: pending&mask; write: W1C acknowledge.
- IRQ_MASK_ID, 8'hF1, read/write mask register.
- ATOMIC_16, 1, 1 = high-byte write is staged and committed on the low-byte write; 0 = each byte writes straight through.
- IRQ_PULSE, 0, 1 = INTERRUPT is a 1-cycle pulse per new event; 0 = level.

Ports:
- CLK  in  1  system clock (100 MHz).
- RESET  in  1  synchronous, active-high reset.
- PORT_ID  in  8  MCU port address.
- OUT_PORT  in  8  MCU write data.
- IO_STRB  in  1  MCU write strobe; may stay high for several CLK cycles.
- IN_PORT  out  8  read data to MCU, combinational from PORT_ID.
- IN_DATA  in  8*N_IN  packed input port values; port k is bits [8k+7:8k].
- OUT_REGS  out  16*N_OUT  packed output registers.
- IRQ_SRC  in  N_IRQ  synchronous interrupt request lines, rising-edge sensitive.
- INTERRUPT  out  1  to MCU INTERRUPTC.

Behaviour:
- Reset, synchronous: OUT_REGS=0, staging bytes=0, mask=0, pending=0, edge-detect history=current IRQ_SRC (no spurious edge after reset), INTERRUPT=0.
- Read mux, combinational, zero latency:
  - IN_BASE+k returns IN_DATA byte k.
  - IRQ_STAT_ID returns zero-extended pending&mask.
  - IRQ_MASK_ID returns zero-extended mask.
  - Output IDs read back the corresponding register byte.
  - Any other ID returns 8'h00.
- Writes: take effect on the CLK edge where IO_STRB=1. Repeated strobe cycles with the same ID/data are idempotent. Writes to unmapped or input IDs are ignored.
- ATOMIC_16=0: low-byte ID writes OUT_REGS[i][7:0]; high-byte ID writes [15:8]. New value visible 1 cycle after the strobe edge.
- ATOMIC_16=1: a high-byte write loads stage[i] only. A low-byte write commits {stage[i], OUT_PORT} to OUT_REGS[i] in one edge, so both bytes change on the same cycle. The stage holds its value; it is not cleared by the commit.
- IRQ edge detect: hist <= IRQ_SRC every cycle; rise = IRQ_SRC & ~hist.
- Pending: pending <= (pending & ~clr) | rise. clr = OUT_PORT[N_IRQ-1:0] when a write hits IRQ_STAT_ID, else 0.
  - Set wins when a rise and a clear of the same bit fall on the same edge.
- Mask write updates mask[N_IRQ-1:0]; upper data bits are ignored. Masked sources still latch pending, and INTERRUPT asserts the cycle after unmask.
- Level mode: INTERRUPT <= |(pending&mask); registered, 1 cycle after the event edge.
- Pulse mode: INTERRUPT <= 1 for exactly one cycle whenever a new bit becomes set in pending&mask. A later second source produces another pulse.
- Parameter check: elaboration error if any ID ranges overlap, N_IRQ>8, or a range exceeds 8'hFF.

Decomposition:
- Package rat_io_pkg: default port-ID constants (SWITCHES_ID=8'h20, KEYPAD_ID=8'h21, LEDS_ID=8'h40, SEVSEG_ID=8'h42, SPEAKER_ID=8'h44, IRQ IDs) and the N_IRQ maximum.
- Sub-module rat_irq_ctrl holds the edge detect, pending, mask, W1C logic and INTERRUPT generation. The hub instantiates it and decodes its IDs.

Test Plan:
- Reset, then PORT_ID=8'h21 with IN_DATA=16'hA55A → IN_PORT=8'hA5; PORT_ID=8'h30 → 8'h00.
- ATOMIC_16=1: write 8'h12 to 8'h43, then 8'h34 to 8'h42 → OUT_REGS[1] stays 16'h0000 after the first write and becomes 16'h1234 on the cycle after the second strobe.
- Mask=8'h05, pulse IRQ_SRC[0] → INTERRUPT=1 one cycle later; IRQ_STAT_ID reads 8'h01; write 8'h01 to 8'hF0 → INTERRUPT=0 next cycle.
- IRQ_SRC[1] rises with mask bit 1 clear → no interrupt, pending bit set; then write mask 8'h02 → INTERRUPT=1 next cycle.
- W1C of bit 2 on the same edge as a new rise of IRQ_SRC[2] → bit stays pending and INTERRUPT stays high.
- Assert RESET mid-sequence with pending=8'h03 and OUT_REGS nonzero → all cleared next edge; IRQ_SRC held high through reset produces no interrupt.

Source files
------------

// File: rtl/rat_io_pkg.sv
// Shared port-ID map and configuration helpers for the RAT MCU I/O hub.
package rat_io_pkg;

    localparam logic [7:0] SWITCHES_ID     = 8'h20;
    localparam logic [7:0] KEYPAD_ID       = 8'h21;
    localparam logic [7:0] LEDS_ID         = 8'h40;
    localparam logic [7:0] SEVSEG_ID       = 8'h42;
    localparam logic [7:0] SPEAKER_ID      = 8'h44;
    localparam logic [7:0] IRQ_STAT_ID_DEF = 8'hF0;
    localparam logic [7:0] IRQ_MASK_ID_DEF = 8'hF1;
    localparam int         N_IRQ_MAX       = 8;

    // Half-open ID ranges [lo, lo+n) overlap test used by the elaboration check.
    function automatic bit ranges_overlap(input int a_lo, input int a_n,
                                          input int b_lo, input int b_n);
        return (a_lo < (b_lo + b_n)) && (b_lo < (a_lo + a_n));
    endfunction

endpackage

// File: rtl/rat_irq_ctrl.sv
// Interrupt controller: rising-edge capture, pending/mask registers,
// write-1-to-clear acknowledge and level or pulse INTERRUPT generation.
module rat_irq_ctrl
    import rat_io_pkg::*;
#(
    parameter int N_IRQ     = 4,
    parameter bit IRQ_PULSE = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_IRQ-1:0] IRQ_SRC,
    input  logic             MASK_WE,
    input  logic             CLR_WE,
    input  logic [N_IRQ-1:0] WDATA,
    output logic [N_IRQ-1:0] PEND_MASKED,
    output logic [N_IRQ-1:0] MASK,
    output logic             INTERRUPT
);

    logic [N_IRQ-1:0] hist_r;
    logic [N_IRQ-1:0] pending_r;
    logic [N_IRQ-1:0] mask_r;
    logic             irq_r;
    logic [N_IRQ-1:0] rise_s;
    logic [N_IRQ-1:0] clr_s;
    logic [N_IRQ-1:0] pend_next_s;
    logic [N_IRQ-1:0] mask_next_s;
    logic [N_IRQ-1:0] active_next_s;
    logic             irq_next_s;

    // Next-state of pending/mask; INTERRUPT follows the state being written this edge.
    always_comb begin
        rise_s = IRQ_SRC & ~hist_r;
        if (CLR_WE) begin
            clr_s = WDATA;
        end else begin
            clr_s = {N_IRQ{1'b0}};
        end
        // OR-ing rise after the clear makes a same-edge set win.
        pend_next_s = (pending_r & ~clr_s) | rise_s;
        if (MASK_WE) begin
            mask_next_s = WDATA;
        end else begin
            mask_next_s = mask_r;
        end
        active_next_s = pend_next_s & mask_next_s;
        if (IRQ_PULSE) begin
            irq_next_s = |(active_next_s & ~(pending_r & mask_r));
        end else begin
            irq_next_s = |active_next_s;
        end
    end

    // Edge history, pending, mask and interrupt registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hist_r    <= IRQ_SRC;
            pending_r <= {N_IRQ{1'b0}};
            mask_r    <= {N_IRQ{1'b0}};
            irq_r     <= 1'b0;
        end else begin
            hist_r    <= IRQ_SRC;
            pending_r <= pend_next_s;
            mask_r    <= mask_next_s;
            irq_r     <= irq_next_s;
        end
    end

    assign PEND_MASKED = pending_r & mask_r;
    assign MASK        = mask_r;
    assign INTERRUPT   = irq_r;

endmodule

// File: rtl/rat_io_hub.sv
// Port-I/O hub for the RAT MCU: PORT_ID decode to input bytes, 16-bit output
// registers (optionally committed atomically) and the interrupt controller.
module rat_io_hub
    import rat_io_pkg::*;
#(
    parameter int         N_IN        = 2,
    parameter int         N_OUT       = 3,
    parameter int         N_IRQ       = 4,
    parameter logic [7:0] IN_BASE     = SWITCHES_ID,
    parameter logic [7:0] OUT_BASE    = LEDS_ID,
    parameter logic [7:0] IRQ_STAT_ID = IRQ_STAT_ID_DEF,
    parameter logic [7:0] IRQ_MASK_ID = IRQ_MASK_ID_DEF,
    parameter bit         ATOMIC_16   = 1'b1,
    parameter bit         IRQ_PULSE   = 1'b0
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [7:0]          PORT_ID,
    input  logic [7:0]          OUT_PORT,
    input  logic                IO_STRB,
    output logic [7:0]          IN_PORT,
    input  logic [8*N_IN-1:0]   IN_DATA,
    output logic [16*N_OUT-1:0] OUT_REGS,
    input  logic [N_IRQ-1:0]    IRQ_SRC,
    output logic                INTERRUPT
);

    localparam int IN_LO   = int'(IN_BASE);
    localparam int OUT_LO  = int'(OUT_BASE);
    localparam int STAT_LO = int'(IRQ_STAT_ID);
    localparam int MASK_LO = int'(IRQ_MASK_ID);

    localparam bit CFG_BAD =
        (N_IRQ < 1) || (N_IRQ > N_IRQ_MAX) || (N_IN < 1) || (N_OUT < 1) ||
        ((IN_LO + N_IN) > 256) || ((OUT_LO + 2 * N_OUT) > 256) ||
        ranges_overlap(IN_LO, N_IN, OUT_LO, 2 * N_OUT) ||
        ranges_overlap(IN_LO, N_IN, STAT_LO, 1) ||
        ranges_overlap(IN_LO, N_IN, MASK_LO, 1) ||
        ranges_overlap(OUT_LO, 2 * N_OUT, STAT_LO, 1) ||
        ranges_overlap(OUT_LO, 2 * N_OUT, MASK_LO, 1) ||
        (STAT_LO == MASK_LO);

    if (CFG_BAD) begin : g_cfg_check
        $error("rat_io_hub: overlapping or out-of-range port IDs, or N_IRQ outside 1..8");
    end

    logic [N_OUT-1:0][15:0] out_regs_r;
    logic [N_OUT-1:0][7:0]  stage_r;
    logic [7:0]             rd_s;
    logic                   stat_we_s;
    logic                   mask_we_s;
    logic [N_IRQ-1:0]       pend_masked_s;
    logic [N_IRQ-1:0]       mask_s;

    assign stat_we_s = IO_STRB && (PORT_ID == IRQ_STAT_ID);
    assign mask_we_s = IO_STRB && (PORT_ID == IRQ_MASK_ID);

    // Zero-latency read mux; unmapped IDs return zero.
    always_comb begin
        rd_s = 8'h00;
        for (int k = 0; k < N_IN; k++) begin
            rd_s = (PORT_ID == 8'(IN_LO + k)) ? IN_DATA[8*k +: 8] : rd_s;
        end
        for (int i = 0; i < N_OUT; i++) begin
            rd_s = (PORT_ID == 8'(OUT_LO + 2 * i))     ? out_regs_r[i][7:0]  : rd_s;
            rd_s = (PORT_ID == 8'(OUT_LO + 2 * i + 1)) ? out_regs_r[i][15:8] : rd_s;
        end
        rd_s = (PORT_ID == IRQ_STAT_ID) ? 8'(pend_masked_s) : rd_s;
        rd_s = (PORT_ID == IRQ_MASK_ID) ? 8'(mask_s)        : rd_s;
    end

    assign IN_PORT = rd_s;

    // Output register and high-byte staging writes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_regs_r <= '0;
            stage_r    <= '0;
        end else if (IO_STRB) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (PORT_ID == 8'(OUT_LO + 2 * i)) begin
                    if (ATOMIC_16) begin
                        out_regs_r[i] <= {stage_r[i], OUT_PORT};
                    end else begin
                        out_regs_r[i][7:0] <= OUT_PORT;
                    end
                end else if (PORT_ID == 8'(OUT_LO + 2 * i + 1)) begin
                    if (ATOMIC_16) begin
                        stage_r[i] <= OUT_PORT;
                    end else begin
                        out_regs_r[i][15:8] <= OUT_PORT;
                    end
                end
            end
        end
    end

    assign OUT_REGS = out_regs_r;

    rat_irq_ctrl #(
        .N_IRQ     (N_IRQ),
        .IRQ_PULSE (IRQ_PULSE)
    ) u_irq (
        .CLK         (CLK),
        .RESET       (RESET),
        .IRQ_SRC     (IRQ_SRC),
        .MASK_WE     (mask_we_s),
        .CLR_WE      (stat_we_s),
        .WDATA       (OUT_PORT[N_IRQ-1:0]),
        .PEND_MASKED (pend_masked_s),
        .MASK        (mask_s),
        .INTERRUPT   (INTERRUPT)
    );

endmodule
